reg_file_sb: RTL and testbench

// Parametrised register file with N combinational read ports, one synchronous write port,

---
 rtl/reg_file_sb_pkg.sv | 20 ++
 rtl/reg_file_sb_if.sv | 39 +++
 rtl/reg_file_sb_scoreboard.sv | 73 +++++++
 rtl/reg_file_sb.sv | 71 +++++++
 tb/tb_reg_file_sb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_pkg : shared widths and types for the register file / scoreboard    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int REG_DATA_W = 8;
  localparam int REG_ADDR_W = 4;
  localparam int DEPTH      = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [DEPTH-1:0]      busy_vec_t;
  typedef logic [REG_ADDR_W:0]   cnt_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_sb_if.sv
// +----------------------------------------------------------------------------+
// | reg_file_sb_if : decode/writeback bus of the register file                  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD-1:0][ADDR_W-1:0] RdAddr;
  logic [NUM_RD-1:0][DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]             RdBusy;
  logic                          WrEn;
  logic [ADDR_W-1:0]             WrAddr;
  logic [DATA_W-1:0]             WrData;
  logic                          ResvEn;
  logic [ADDR_W-1:0]             ResvAddr;
  logic                          Flush;
  logic [ADDR_W:0]               BusyCnt;
  logic                          ResvErr;

  modport master (
    output RdAddr, WrEn, WrAddr, WrData, ResvEn, ResvAddr, Flush,
    input  RdData, RdBusy, BusyCnt, ResvErr
  );

  modport slave (
    input  RdAddr, WrEn, WrAddr, WrData, ResvEn, ResvAddr, Flush,
    output RdData, RdBusy, BusyCnt, ResvErr
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_sb_scoreboard.sv
// +----------------------------------------------------------------------------+
// | reg_scoreboard : busy bits, busy count and sticky reservation error         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_scoreboard #(
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_wr_en,
  input  wire logic [ADDR_W-1:0]        i_wr_addr,
  input  wire logic                     i_resv_en,
  input  wire logic [ADDR_W-1:0]        i_resv_addr,
  input  wire logic                     i_flush,
  output logic      [(2**ADDR_W)-1:0]   o_busy,
  output logic      [ADDR_W:0]          o_busy_cnt,
  output logic                          o_resv_err
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [c_DEPTH-1:0] r_busy;
  logic [ADDR_W:0]    r_cnt;
  logic               r_err;

  logic               w_wr_ok;
  logic               w_resv_ok;
  logic               w_inc;
  logic               w_dec;
  logic               w_err;
  logic [c_DEPTH-1:0] w_busy_nxt;

  always_comb begin
    w_wr_ok    = i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == '0));
    w_resv_ok  = i_resv_en && !i_flush && !((ZERO_REG != 0) && (i_resv_addr == '0));
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr_ok)   w_busy_nxt[i_wr_addr]   = 1'b0;
      if (w_resv_ok) w_busy_nxt[i_resv_addr] = 1'b1;
    end
    // A set and clear on the same register cancel: the bit simply stays set.
    w_inc = w_resv_ok && !r_busy[i_resv_addr];
    w_dec = !i_flush && w_wr_ok && r_busy[i_wr_addr]
            && !(w_resv_ok && (i_resv_addr == i_wr_addr));
    w_err = w_resv_ok && r_busy[i_resv_addr]
            && !(i_wr_en && (i_wr_addr == i_resv_addr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (i_flush) r_cnt <= '0;
      else         r_cnt <= r_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
      if (w_err)   r_err <= 1'b1;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;
  assign o_resv_err = r_err;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// +----------------------------------------------------------------------------+
// | reg_file_sb : register file with N read ports, bypass and scoreboard        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input wire logic    CLK,
  input wire logic    Reset,
  reg_file_sb_if.slave bus
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] w_busy;
  logic               w_wr_ok;

  assign w_wr_ok = bus.WrEn && !((ZERO_REG != 0) && (bus.WrAddr == '0));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < c_DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.WrAddr] <= bus.WrData;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (CLK),
    .rst         (Reset),
    .i_wr_en     (bus.WrEn),
    .i_wr_addr   (bus.WrAddr),
    .i_resv_en   (bus.ResvEn),
    .i_resv_addr (bus.ResvAddr),
    .i_flush     (bus.Flush),
    .o_busy      (w_busy),
    .o_busy_cnt  (bus.BusyCnt),
    .o_resv_err  (bus.ResvErr)
  );

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic w_zero;
      logic w_byp;

      assign w_zero = (ZERO_REG != 0) && (bus.RdAddr[g] == '0);
      assign w_byp  = (BYPASS != 0) && bus.WrEn && (bus.WrAddr == bus.RdAddr[g]);

      // Zero register wins over bypass, so a write to r0 never leaks onto a read.
      assign bus.RdData[g] = (Reset || w_zero) ? '0 :
                             w_byp             ? bus.WrData :
                                                 r_mem[bus.RdAddr[g]];
      assign bus.RdBusy[g] = !Reset && w_busy[bus.RdAddr[g]] && !w_byp;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// +----------------------------------------------------------------------------+
// | tb_reg_file_sb : directed checks on bypassing and non-bypassing instances   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_file_sb;
  import regfile_pkg::*;

  logic            CLK;
  logic            Reset;
  logic [1:0][3:0] RdAddr;
  logic            WrEn;
  logic [3:0]      WrAddr;
  logic [7:0]      WrData;
  logic            ResvEn;
  logic [3:0]      ResvAddr;
  logic            Flush;

  int n_pass;
  int n_total;

  reg_file_sb_if #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2)) if1 ();
  reg_file_sb_if #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2)) if0 ();

  assign if1.RdAddr = RdAddr;   assign if0.RdAddr = RdAddr;
  assign if1.WrEn   = WrEn;     assign if0.WrEn   = WrEn;
  assign if1.WrAddr = WrAddr;   assign if0.WrAddr = WrAddr;
  assign if1.WrData = WrData;   assign if0.WrData = WrData;
  assign if1.ResvEn = ResvEn;   assign if0.ResvEn = ResvEn;
  assign if1.ResvAddr = ResvAddr; assign if0.ResvAddr = ResvAddr;
  assign if1.Flush  = Flush;    assign if0.Flush  = Flush;

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    dut1 (.CLK(CLK), .Reset(Reset), .bus(if1));
  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
    dut0 (.CLK(CLK), .Reset(Reset), .bus(if0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WrEn = 1'b0; WrAddr = '0; WrData = '0;
    ResvEn = 1'b0; ResvAddr = '0; Flush = 1'b0;
  endtask

  task automatic test_reset();
    reg_data_t exp_d;
    WrEn = 1'b1; WrAddr = 4'd3; WrData = 8'hA5;
    ResvEn = 1'b1; ResvAddr = 4'd3;
    tick();
    idle();
    RdAddr[0] = 4'd3;
    #1;
    n_total++;
    if (if1.RdData[0] !== 8'hA5) $display("FAIL pre_reset_data: got %h want a5", if1.RdData[0]);
    else n_pass++;
    #2 Reset = 1'b1;
    #1;
    exp_d = 8'h00;
    n_total++;
    if (if1.RdData[0] !== exp_d) $display("FAIL reset_data: got %h want %h", if1.RdData[0], exp_d);
    else n_pass++;
    n_total++;
    if (if1.RdBusy[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", if1.RdBusy[0]);
    else n_pass++;
    @(negedge CLK);
    Reset = 1'b0;
    tick();
    n_total++;
    if (if1.BusyCnt !== 5'd0 || if1.ResvErr !== 1'b0)
      $display("FAIL reset_cnt_err: got cnt=%0d err=%b want cnt=0 err=0", if1.BusyCnt, if1.ResvErr);
    else n_pass++;
    n_total++;
    if (if1.RdData[0] !== 8'h00) $display("FAIL reset_cleared_r3: got %h want 00", if1.RdData[0]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    WrEn = 1'b1; WrAddr = 4'd5; WrData = 8'h3C;
    RdAddr[0] = 4'd5;
    #1;
    n_total++;
    if (if1.RdData[0] !== 8'h3C) $display("FAIL bypass_same_cycle: got %h want 3c", if1.RdData[0]);
    else n_pass++;
    n_total++;
    if (if0.RdData[0] !== 8'h00) $display("FAIL nobypass_same_cycle: got %h want 00", if0.RdData[0]);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (if0.RdData[0] !== 8'h3C) $display("FAIL nobypass_next_cycle: got %h want 3c", if0.RdData[0]);
    else n_pass++;
  endtask

  task automatic test_reserve();
    ResvEn = 1'b1; ResvAddr = 4'd7;
    tick();
    n_total++;
    if (if1.BusyCnt !== 5'd1) $display("FAIL resv_cnt1: got %0d want 1", if1.BusyCnt);
    else n_pass++;
    ResvAddr = 4'd9;
    tick();
    idle();
    RdAddr[0] = 4'd7; RdAddr[1] = 4'd9;
    #1;
    n_total++;
    if (if1.BusyCnt !== 5'd2) $display("FAIL resv_cnt2: got %0d want 2", if1.BusyCnt);
    else n_pass++;
    n_total++;
    if (if1.RdBusy !== 2'b11) $display("FAIL resv_rdbusy: got %b want 11", if1.RdBusy);
    else n_pass++;
    WrEn = 1'b1; WrAddr = 4'd7; WrData = 8'h77;
    #1;
    n_total++;
    if (if1.RdBusy[0] !== 1'b0 || if0.RdBusy[0] !== 1'b1)
      $display("FAIL wb_busy_bypass: got byp=%b nobyp=%b want byp=0 nobyp=1", if1.RdBusy[0], if0.RdBusy[0]);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (if1.BusyCnt !== 5'd1 || if0.BusyCnt !== 5'd1)
      $display("FAIL wb_cnt: got %0d/%0d want 1/1", if1.BusyCnt, if0.BusyCnt);
    else n_pass++;
    n_total++;
    if (if0.RdData[0] !== 8'h77 || if0.RdBusy[0] !== 1'b0)
      $display("FAIL wb_data: got %h busy=%b want 77 busy=0", if0.RdData[0], if0.RdBusy[0]);
    else n_pass++;
  endtask

  task automatic test_same_reg();
    ResvEn = 1'b1; ResvAddr = 4'd4;
    tick();
    WrEn = 1'b1; WrAddr = 4'd4; WrData = 8'h44;
    tick();
    idle();
    RdAddr[0] = 4'd4;
    #1;
    n_total++;
    if (if1.BusyCnt !== 5'd2 || if1.ResvErr !== 1'b0 || if1.RdBusy[0] !== 1'b1)
      $display("FAIL set_wins: got cnt=%0d err=%b busy=%b want cnt=2 err=0 busy=1",
               if1.BusyCnt, if1.ResvErr, if1.RdBusy[0]);
    else n_pass++;
    ResvEn = 1'b1; ResvAddr = 4'd4;
    tick();
    idle();
    tick();
    n_total++;
    if (if1.ResvErr !== 1'b1 || if1.BusyCnt !== 5'd2)
      $display("FAIL resv_err_sticky: got err=%b cnt=%0d want err=1 cnt=2", if1.ResvErr, if1.BusyCnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [3:0] regs [3];
    regs[0] = 4'd1; regs[1] = 4'd3; regs[2] = 4'd5;
    for (int i = 0; i < 3; i++) begin
      ResvEn = 1'b1; ResvAddr = regs[i];
      tick();
    end
    idle();
    #1;
    n_total++;
    if (if1.BusyCnt !== 5'd5) $display("FAIL five_busy: got %0d want 5", if1.BusyCnt);
    else n_pass++;
    Flush = 1'b1; ResvEn = 1'b1; ResvAddr = 4'd2;
    WrEn = 1'b1; WrAddr = 4'd6; WrData = 8'h11;
    tick();
    idle();
    RdAddr[0] = 4'd2; RdAddr[1] = 4'd6;
    #1;
    n_total++;
    if (if1.BusyCnt !== 5'd0 || if0.BusyCnt !== 5'd0)
      $display("FAIL flush_cnt: got %0d/%0d want 0/0", if1.BusyCnt, if0.BusyCnt);
    else n_pass++;
    n_total++;
    if (if1.RdBusy !== 2'b00 || if1.RdData[1] !== 8'h11)
      $display("FAIL flush_state: got busy=%b r6=%h want busy=00 r6=11", if1.RdBusy, if1.RdData[1]);
    else n_pass++;
    n_total++;
    if (if1.ResvErr !== 1'b1) $display("FAIL flush_keeps_err: got %b want 1", if1.ResvErr);
    else n_pass++;
    RdAddr[0] = 4'd6;
    #1;
    n_total++;
    if (if1.RdData !== {8'h11, 8'h11}) $display("FAIL alias_read: got %h want 1111", if1.RdData);
    else n_pass++;
  endtask

  task automatic test_zero();
    WrEn = 1'b1; WrAddr = 4'd0; WrData = 8'hFF;
    ResvEn = 1'b1; ResvAddr = 4'd0;
    RdAddr[0] = 4'd0;
    #1;
    n_total++;
    if (if1.RdData[0] !== 8'h00 || if1.RdBusy[0] !== 1'b0)
      $display("FAIL zero_same_cycle: got %h busy=%b want 00 busy=0", if1.RdData[0], if1.RdBusy[0]);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (if1.RdData[0] !== 8'h00 || if0.RdData[0] !== 8'h00 || if1.RdBusy[0] !== 1'b0)
      $display("FAIL zero_next_cycle: got %h/%h busy=%b want 00/00 busy=0",
               if1.RdData[0], if0.RdData[0], if1.RdBusy[0]);
    else n_pass++;
    n_total++;
    if (if1.BusyCnt !== 5'd0) $display("FAIL zero_cnt: got %0d want 0", if1.BusyCnt);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    Reset   = 1'b1;
    RdAddr  = '0;
    idle();
    #1;
    n_total++;
    if (if1.BusyCnt !== 5'd0 || if1.RdData !== 16'h0000 || if1.RdBusy !== 2'b00)
      $display("FAIL init_reset: got cnt=%0d data=%h busy=%b want 0/0000/00",
               if1.BusyCnt, if1.RdData, if1.RdBusy);
    else n_pass++;
    #12 Reset = 1'b0;
    tick();
    test_reset();
    test_bypass();
    test_reserve();
    test_same_reg();
    test_flush();
    test_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
